// File: rtl/bram_port_arbiter_if.sv
// rtl/bram_port_arbiter_if.sv - two requester ports plus BRAM-side signals of the arbiter
interface bram_port_arbiter_if;
  logic        a_req_valid;
  logic        a_req_ready;
  logic        a_req_we;
  logic [7:0]  a_req_addr;
  logic [31:0] a_req_wdata;
  logic        a_rsp_valid;
  logic [31:0] a_rsp_rdata;

  logic        b_req_valid;
  logic        b_req_ready;
  logic        b_req_we;
  logic [7:0]  b_req_addr;
  logic [31:0] b_req_wdata;
  logic        b_rsp_valid;
  logic [31:0] b_rsp_rdata;

  logic [7:0]  bram_rd_addr;
  logic [7:0]  bram_wr_addr;
  logic [31:0] bram_wr_data;
  logic [31:0] bram_rd_data;
  logic [7:0]  bram_config;
  logic        init_done;

  modport slave (
    input  a_req_valid, a_req_we, a_req_addr, a_req_wdata,
    input  b_req_valid, b_req_we, b_req_addr, b_req_wdata,
    input  bram_rd_data,
    output a_req_ready, a_rsp_valid, a_rsp_rdata,
    output b_req_ready, b_rsp_valid, b_rsp_rdata,
    output bram_rd_addr, bram_wr_addr, bram_wr_data, bram_config, init_done
  );

  modport master (
    output a_req_valid, a_req_we, a_req_addr, a_req_wdata,
    output b_req_valid, b_req_we, b_req_addr, b_req_wdata,
    output bram_rd_data,
    input  a_req_ready, a_rsp_valid, a_rsp_rdata,
    input  b_req_ready, b_rsp_valid, b_rsp_rdata,
    input  bram_rd_addr, bram_wr_addr, bram_wr_data, bram_config, init_done
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - two-port round-robin BRAM arbiter with power-up init sweep
module bram_port_arbiter #(
  parameter logic [7:0]  CFG_WR    = 8'h10,
  parameter logic [7:0]  CFG_RD    = 8'h00,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] INIT_DATA = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  bram_port_arbiter_if.slave bus
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                init_done_q, init_done_d;
  logic                last_b_q, last_b_d;
  logic [RD_LAT-1:0]   tag_v_q, tag_v_d;
  logic [RD_LAT-1:0]   tag_b_q, tag_b_d;
  logic [7:0]          rd_addr_q, rd_addr_d;
  logic [7:0]          wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;

  logic        run;
  logic        grant_a, grant_b, grant;
  logic        gnt_we;
  logic [7:0]  gnt_addr;
  logic [31:0] gnt_wdata;
  logic [7:0]  cfg;

  // A wins a tie only when B was granted last; each ready looks at valids, never at the other ready.
  assign run       = (state_q == ST_RUN);
  assign grant_a   = run && bus.a_req_valid && (!bus.b_req_valid || last_b_q);
  assign grant_b   = run && bus.b_req_valid && (!bus.a_req_valid || !last_b_q);
  assign grant     = grant_a || grant_b;
  assign gnt_we    = grant_a ? bus.a_req_we    : bus.b_req_we;
  assign gnt_addr  = grant_a ? bus.a_req_addr  : bus.b_req_addr;
  assign gnt_wdata = grant_a ? bus.a_req_wdata : bus.b_req_wdata;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    last_b_d    = last_b_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    cfg         = CFG_RD;
    tag_v_d[0]  = grant && !gnt_we;
    tag_b_d[0]  = grant_b;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_b_d[i] = tag_b_q[i-1];
    end

    if (!run) begin
      wr_addr_d = cnt_q;
      wr_data_d = INIT_DATA;
      cfg       = CFG_WR;
      cnt_d     = cnt_q + 8'd1;
      if (cnt_q == 8'hFF) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end else if (grant) begin
      last_b_d = grant_b;
      if (gnt_we) begin
        wr_addr_d = gnt_addr;
        wr_data_d = gnt_wdata;
        cfg       = CFG_WR;
      end else begin
        rd_addr_d = gnt_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= 8'h00;
      init_done_q <= 1'b0;
      last_b_q    <= 1'b1;
      tag_v_q     <= '0;
      tag_b_q     <= '0;
      rd_addr_q   <= 8'h00;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      last_b_q    <= last_b_d;
      tag_v_q     <= tag_v_d;
      tag_b_q     <= tag_b_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // The next-state shadow doubles as the live drive: it equals the held value when nothing is granted.
  assign bus.bram_rd_addr = rd_addr_d;
  assign bus.bram_wr_addr = wr_addr_d;
  assign bus.bram_wr_data = wr_data_d;
  assign bus.bram_config  = cfg;
  assign bus.init_done    = init_done_q;

  assign bus.a_req_ready = grant_a;
  assign bus.b_req_ready = grant_b;

  assign bus.a_rsp_valid = tag_v_q[RD_LAT-1] && !tag_b_q[RD_LAT-1];
  assign bus.b_rsp_valid = tag_v_q[RD_LAT-1] &&  tag_b_q[RD_LAT-1];
  assign bus.a_rsp_rdata = bus.a_rsp_valid ? bus.bram_rd_data : 32'h0;
  assign bus.b_rsp_rdata = bus.b_rsp_valid ? bus.bram_rd_data : 32'h0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - directed bench with cycle-level model for bram_port_arbiter
module tb_bram_port_arbiter;
  localparam int          LAT   = 2;
  localparam logic [7:0]  CWR   = 8'h10;
  localparam logic [7:0]  CRD   = 8'h00;
  localparam logic [31:0] IDATA = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_port_arbiter_if bus();

  bram_port_arbiter #(.CFG_WR(CWR), .CFG_RD(CRD), .RD_LAT(LAT), .INIT_DATA(IDATA)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // BRAM: synchronous write, read data delayed LAT cycles from the address
  logic [31:0] mem [256];
  logic [31:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem[bus.bram_rd_addr];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (bus.bram_config == CWR) mem[bus.bram_wr_addr] <= bus.bram_wr_data;
  end
  assign bus.bram_rd_data = rd_pipe[LAT-1];

  // Model: memory contents, expected responses with due cycle, arbitration history
  typedef struct {
    bit          id_b;
    int          due;
    logic [31:0] data;
  } rsp_t;

  rsp_t        rq[$];
  logic [31:0] mem_m [256];
  bit          known = 0, m_init = 1, m_done = 0, m_last_b = 1;
  int          m_cnt = 0, cyc = 0;
  logic [7:0]  m_rd = 0, m_wr = 0;
  logic [31:0] m_wd = 0;
  bit          ea, eb, ewe, ear, ebr;
  logic [7:0]  eaddr, ecfg, erd, ewr;
  logic [31:0] ewdat, ewd, ead, ebd;

  always @(negedge clk) begin
    if (known) begin
      ea = 0; eb = 0; ewe = 0; eaddr = 0; ewdat = 0;
      erd = m_rd; ewr = m_wr; ewd = m_wd;
      if (m_init) begin
        ecfg = CWR; ewr = m_cnt[7:0]; ewd = IDATA;
      end else begin
        ecfg = CRD;
        ea = bus.a_req_valid && (!bus.b_req_valid || m_last_b);
        eb = bus.b_req_valid && !ea;
        if (ea || eb) begin
          ewe   = ea ? bus.a_req_we : bus.b_req_we;
          eaddr = ea ? bus.a_req_addr : bus.b_req_addr;
          ewdat = ea ? bus.a_req_wdata : bus.b_req_wdata;
          if (ewe) begin ecfg = CWR; ewr = eaddr; ewd = ewdat; end
          else erd = eaddr;
        end
      end
      chk("a_req_ready", bus.a_req_ready, ea);
      chk("b_req_ready", bus.b_req_ready, eb);
      chk("bram_config", bus.bram_config, ecfg);
      chk("bram_rd_addr", bus.bram_rd_addr, erd);
      chk("bram_wr_addr", bus.bram_wr_addr, ewr);
      chk("bram_wr_data", bus.bram_wr_data, ewd);
      chk("init_done", bus.init_done, m_done);
      ear = 0; ebr = 0; ead = 0; ebd = 0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        if (rq[0].id_b) begin ebr = 1; ebd = rq[0].data; end
        else begin ear = 1; ead = rq[0].data; end
      end
      chk("a_rsp_valid", bus.a_rsp_valid, ear);
      chk("a_rsp_rdata", bus.a_rsp_rdata, ead);
      chk("b_rsp_valid", bus.b_rsp_valid, ebr);
      chk("b_rsp_rdata", bus.b_rsp_rdata, ebd);
    end
    if (!rst_n) begin
      known = 1; m_init = 1; m_done = 0; m_cnt = 0; m_last_b = 1;
      rq.delete(); m_rd = 0; m_wr = 0; m_wd = 0;
    end else if (known) begin
      if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
      if (m_init) begin
        mem_m[m_cnt] = IDATA; m_wr = m_cnt[7:0]; m_wd = IDATA;
        m_cnt++;
        if (m_cnt == 256) begin m_init = 0; m_done = 1; end
      end else if (ea || eb) begin
        m_last_b = eb;
        if (ewe) begin
          mem_m[eaddr] = ewdat; m_wr = eaddr; m_wd = ewdat;
        end else begin
          rq.push_back('{eb, cyc + LAT, mem_m[eaddr]});
          m_rd = eaddr;
        end
      end
    end
    cyc++;
  end

  // Inputs change 1 time unit after the rising edge; directed checks run just after the falling edge
  task automatic go(input bit rst, input bit av, input bit aw, input logic [7:0] aa, input logic [31:0] ad,
                    input bit bv, input bit bw, input logic [7:0] ba, input logic [31:0] bd);
    @(posedge clk);
    #1;
    rst_n = rst;
    bus.a_req_valid = av; bus.a_req_we = aw; bus.a_req_addr = aa; bus.a_req_wdata = ad;
    bus.b_req_valid = bv; bus.b_req_we = bw; bus.b_req_addr = ba; bus.b_req_wdata = bd;
    @(negedge clk);
    #1;
  endtask

  task automatic go_idle();
    go(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int          nrsp;
  logic [7:0]  i8;
  logic [31:0] pat;

  initial begin
    bus.a_req_valid = 0; bus.a_req_we = 0; bus.a_req_addr = 0; bus.a_req_wdata = 0;
    bus.b_req_valid = 0; bus.b_req_we = 0; bus.b_req_addr = 0; bus.b_req_wdata = 0;
    repeat (3) go(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst init_done", bus.init_done, 0);
    chk("rst a_rsp_valid", bus.a_rsp_valid, 0);

    // INIT sweep: cycle k writes address k-1; requesters held valid to show ready stays low
    go_idle();
    chk("init first wr_addr", bus.bram_wr_addr, 8'h00);
    chk("init first cfg", bus.bram_config, 8'h10);
    for (int k = 2; k <= 256; k++) go(1, 1, 0, 8'h01, 0, 1, 0, 8'h02, 0);
    chk("init last wr_addr", bus.bram_wr_addr, 8'hFF);
    chk("init ready a", bus.a_req_ready, 0);
    chk("init_done at 256", bus.init_done, 0);
    go_idle();
    chk("init_done at 257", bus.init_done, 1);

    // A reads 0x05 -> zero after LAT cycles
    go(1, 1, 0, 8'h05, 0, 0, 0, 0, 0);
    chk("rd05 ready", bus.a_req_ready, 1);
    chk("rd05 rd_addr", bus.bram_rd_addr, 8'h05);
    go_idle();
    chk("rd05 early", bus.a_rsp_valid, 0);
    go_idle();
    chk("rd05 valid", bus.a_rsp_valid, 1);
    chk("rd05 data", bus.a_rsp_rdata, 32'h0);
    go_idle();
    chk("rd05 one pulse", bus.a_rsp_valid, 0);

    // A writes DEADBEEF @0x10, B reads it the next cycle
    go(1, 1, 1, 8'h10, 32'hDEAD_BEEF, 0, 0, 0, 0);
    chk("wr cfg", bus.bram_config, 8'h10);
    go(1, 0, 0, 0, 0, 1, 0, 8'h10, 0);
    chk("rd10 b ready", bus.b_req_ready, 1);
    chk("rd10 cfg", bus.bram_config, 8'h00);
    chk("wr shadow hold", bus.bram_wr_data, 32'hDEAD_BEEF);
    go_idle();
    go_idle();
    chk("rd10 b valid", bus.b_rsp_valid, 1);
    chk("rd10 b data", bus.b_rsp_rdata, 32'hDEAD_BEEF);
    chk("rd10 a none", bus.a_rsp_valid, 0);

    // Contention for 6 cycles: A writes 0x30, B reads 0x30 -> A,B,A,B,A,B
    for (int i = 0; i < 6; i++) begin
      go(1, 1, 1, 8'h30, 32'hA000_0000 + i, 1, 0, 8'h30, 0);
      chk("rr a_ready", bus.a_req_ready, (i % 2) == 0);
      chk("rr b_ready", bus.b_req_ready, (i % 2) == 1);
    end
    repeat (LAT + 1) go_idle();

    // Pattern fill then 256 back-to-back reads by A
    for (int i = 0; i < 256; i++) begin
      i8 = i[7:0];
      go(1, 1, 1, i8, {4{i8}}, 0, 0, 0, 0);
    end
    nrsp = 0;
    for (int i = 0; i < 256 + LAT; i++) begin
      i8 = i[7:0];
      if (i < 256) go(1, 1, 0, i8, 0, 0, 0, 0, 0);
      else go_idle();
      if (bus.a_rsp_valid) begin
        i8 = nrsp[7:0];
        pat = {4{i8}};
        chk("sweep data", bus.a_rsp_rdata, pat);
        nrsp++;
      end
    end
    chk("sweep count", nrsp, 256);

    // Reads A@3, B@4, A@5 then reset before the last response
    go(1, 1, 0, 8'h03, 0, 0, 0, 0, 0);
    go(1, 0, 0, 0, 0, 1, 0, 8'h04, 0);
    go(1, 1, 0, 8'h05, 0, 0, 0, 0, 0);
    chk("mid a rsp", bus.a_rsp_valid, 1);
    chk("mid a data", bus.a_rsp_rdata, 32'h0303_0303);
    go(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("mid b rsp", bus.b_rsp_valid, 1);
    go(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("discarded rsp", bus.a_rsp_valid, 0);
    chk("reinit done low", bus.init_done, 0);
    go_idle();
    chk("reinit wr_addr0", bus.bram_wr_addr, 8'h00);
    go_idle();
    chk("reinit wr_addr1", bus.bram_wr_addr, 8'h01);
    repeat (255) go_idle();
    chk("reinit done", bus.init_done, 1);

    // Memory reinitialised: 0x10 reads back INIT_DATA
    go(1, 1, 0, 8'h10, 0, 0, 0, 0, 0);
    go_idle();
    go_idle();
    chk("reinit rd10", bus.a_rsp_rdata, 32'h0);
    chk("reinit rd10 valid", bus.a_rsp_valid, 1);
    repeat (3) go_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameter CFG_WR, default 8'h10, SHALL be the bram_config value for a 32-bit write cycle (write enabled).
REQ-002 Parameter CFG_RD, default 8'h00, SHALL be the bram_config value for a 32-bit read/idle cycle (write disabled).
REQ-003 Parameter RD_LAT, default 1, range 1-3, SHALL be the number of cycles from bram_rd_addr to valid bram_rd_data.
REQ-004 Parameter INIT_DATA, default 32'h0000_0000, SHALL be the word written to every address during init.
REQ-005 Ports SHALL be, clock and reset first:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- a_req_valid / b_req_valid  in  1  request pending.
- a_req_ready / b_req_ready  out  1  request accepted this cycle.
- a_req_we / b_req_we  in  1  1 = write, 0 = read.
- a_req_addr / b_req_addr  in  8  word address.
- a_req_wdata / b_req_wdata  in  32  write data.
- a_rsp_valid / b_rsp_valid  out  1  read data valid, 1-cycle pulse.
- a_rsp_rdata / b_rsp_rdata  out  32  read data.
- bram_rd_addr  out  8  BRAM read address.
- bram_wr_addr  out  8  BRAM write address.
- bram_wr_data  out  32  BRAM write data.
- bram_rd_data  in  32  BRAM read data.
- bram_config  out  8  BRAM mode/write-enable byte.
- init_done  out  1  high once the init sweep has finished.

Function
REQ-006 FSM SHALL have two states: INIT and RUN.
REQ-007 INIT: an 8-bit sweep counter SHALL run 0..255, one address per cycle, driving bram_wr_addr = counter, bram_wr_data = INIT_DATA, bram_config = CFG_WR; both req_ready outputs SHALL be 0.
REQ-008 The FSM SHALL enter RUN on the cycle after address 255 is written (256 INIT cycles); init_done SHALL be registered and go high on entry to RUN, then stay high until reset.
REQ-009 RUN: a handshake SHALL occur when x_req_valid and x_req_ready are both 1; at most one grant SHALL be issued per cycle.
REQ-010 x_req_ready SHALL be combinational: 1 only in RUN, only for the granted requester, and it SHALL NOT depend on x_req_ready of the other port.
REQ-011 Arbitration SHALL be round-robin: if only one requester is valid it is granted; if both are valid, the one not granted last SHALL win; the last-grant register updates only on a handshake.
REQ-012 Granted write: in the same cycle, bram_wr_addr = req_addr, bram_wr_data = req_wdata, bram_config = CFG_WR; no response SHALL be generated.
REQ-013 Granted read: in the same cycle, bram_rd_addr = req_addr and bram_config = CFG_RD; exactly RD_LAT cycles later, x_rsp_valid SHALL pulse for one cycle with x_rsp_rdata = bram_rd_data.
REQ-014 A RD_LAT-deep shift register of {valid, requester id} SHALL tag in-flight reads; responses SHALL be returned in issue order; there is no response backpressure.
REQ-015 A new grant SHALL be allowed every cycle, including back-to-back reads from the same or alternating requesters (full throughput).
REQ-016 Read issued the cycle after a write to the same address SHALL return the written value; a read and a write SHALL never be issued in the same cycle.
REQ-017 With no grant in RUN: bram_config = CFG_RD, and bram_rd_addr, bram_wr_addr, bram_wr_data SHALL hold their last driven values (registered shadow).
REQ-018 Idle rsp_rdata outputs SHALL be 0 when rsp_valid is 0.

Reset
REQ-019 With rst_n = 0 at a clock edge: FSM -> INIT, sweep counter -> 0, last-grant -> B (so A wins the first tie), read tag pipeline cleared, init_done -> 0, rsp_valid -> 0, shadow addresses/data -> 0.
REQ-020 Reset asserted mid-operation SHALL discard in-flight read responses (no rsp_valid after reset) and restart the full INIT sweep.

Verification
REQ-021 Release reset -> 256 cycles of CFG_WR with wr_addr 0..255 and INIT_DATA; init_done rises on cycle 257; ready = 0 throughout INIT.
REQ-022 After init, A reads addr 8'h05 -> a_rsp_valid exactly RD_LAT cycles later with rdata 32'h0.
REQ-023 A writes 32'hDEAD_BEEF to 8'h10, then B reads 8'h10 next cycle -> b_rsp_rdata = 32'hDEAD_BEEF; A sees no response.
REQ-024 A and B both valid continuously for 6 cycles -> grants A,B,A,B,A,B, with one handshake per cycle.
REQ-025 Issue reads A@3, B@4, A@5 back-to-back, then assert rst_n = 0 before the last response -> no further rsp_valid pulses; INIT restarts from address 0.
REQ-026 Back-to-back reads of addresses 0..255 by A after writing pattern {4{addr}} -> every response matches, with 256 reads completed in 256 + RD_LAT cycles.
